// File: rtl/i2c_target_if_pkg.sv
// Shared I2C definitions for the target endpoint and the master-side controller.
package i2c_target_if_pkg;

    // Target protocol states.
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StIdleWait
    } i2c_state_e;

    // Bus address of the colour-sensor target.
    localparam logic [6:0] DefaultTargetAddr = 7'h29;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer and edge detector for one asynchronous I2C line.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Sync chain plus one history flop; resets to the idle-high bus level so no edge is faked.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~hist_q;
    assign fall_o  = ~level_o &  hist_q;

endmodule

// File: rtl/i2c_target_if.sv
// I2C target endpoint: START/STOP detection, address match, register write/read protocol.
module i2c_target_if
    import i2c_target_if_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DefaultTargetAddr,
    parameter int unsigned REG_AW      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .line_i  (scl_in),
        .level_o (scl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .line_i  (sda_in),
        .level_o (sda),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    i2c_state_e        state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [REG_AW-1:0] ptr_q;
    logic              rw_q;
    logic              first_q;   // next write byte loads the pointer
    logic              sda_oe_q;
    logic              busy_q;
    logic              wr_en_q;
    logic [REG_AW-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    // Byte as it stands once the bit on this scl_rise is shifted in.
    logic [7:0] rx_byte;
    assign rx_byte = {shift_q[6:0], sda};

    // Protocol FSM with registered outputs; START/STOP override every bit edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_det) begin
                state_q   <= StAddr;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state_q <= StAddrAck;
                                    rw_q    <= rx_byte[0];
                                    busy_q  <= 1'b1;
                                    first_q <= 1'b1;
                                end else begin
                                    state_q <= StIdle;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    // First scl_fall starts the ACK drive, the second one ends it.
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rw_q) begin
                                shift_q  <= rd_data;
                                sda_oe_q <= ~rd_data[7];
                                state_q  <= StRdByte;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StWrByte;
                            end
                        end
                    end
                    StWrByte: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StWrAck;
                                if (first_q) begin
                                    ptr_q   <= REG_AW'(rx_byte);
                                    first_q <= 1'b0;
                                end else begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= ptr_q;
                                    wr_data_q <= rx_byte;
                                    ptr_q     <= ptr_q + REG_AW'(1);
                                end
                            end
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StWrByte;
                            end
                        end
                    end
                    // Shift on scl_rise so shift_q[7] always holds the bit for the next low phase.
                    StRdByte: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StRdAck;
                            end else begin
                                sda_oe_q <= ~shift_q[7];
                            end
                        end
                    end
                    // Each byte handed out advances the pointer; only an ACK continues the read.
                    StRdAck: begin
                        if (scl_rise) begin
                            ptr_q <= ptr_q + REG_AW'(1);
                            if (sda) begin
                                state_q <= StIdleWait;
                            end
                        end else if (scl_fall) begin
                            shift_q  <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                            state_q  <= StRdByte;
                        end
                    end
                    StIdle, StIdleWait: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = ptr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_if.sv
// Bench for i2c_target_if: bus-level master tasks checked against a pointer/register model.
module tb_i2c_target_if;

    localparam logic [6:0] TARGET = 7'h29;
    localparam int unsigned QCYC  = 6;   // clk cycles per quarter SCL period

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       master_scl;
    logic       master_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    logic [7:0] regs [256];
    assign rd_data = regs[rd_addr];
    assign sda_bus = master_sda & ~sda_oe;

    i2c_target_if u_dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .scl_in  (master_scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitors: write strobes, SDA drive cycles, SDA-drive changes while SCL is high.
    logic [15:0] wr_log[$];
    int          oe_cycles = 0;
    int          oe_viol   = 0;
    logic        oe_prev   = 1'b0;

    always @(negedge clk_in) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cycles++;
        if (sda_oe != oe_prev && master_scl) oe_viol++;
        oe_prev <= sda_oe;
    end

    // Reference model: register pointer and expected write strobes.
    logic [7:0]  m_ptr;
    logic [15:0] exp_wr[$];
    logic [7:0]  tx_q[$];

    task automatic wait_q();
        repeat (QCYC) @(posedge clk_in);
        #1;
    endtask

    task automatic i2c_start();
        master_sda = 1'b1; wait_q();
        master_scl = 1'b1; wait_q();
        master_sda = 1'b0; wait_q();
        master_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        master_sda = 1'b0; wait_q();
        master_scl = 1'b1; wait_q();
        master_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, output logic seen);
        master_sda = b;    wait_q();
        master_scl = 1'b1; wait_q();
        seen = sda_bus;    wait_q();
        master_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic seen;
        for (int i = 7; i >= 0; i--) send_bit(b[i], seen);
        send_bit(1'b1, seen);
        acked = ~seen;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, seen);
            d[i] = seen;
        end
        send_bit(nack, seen);
    endtask

    task automatic check_writes(input int base);
        check_val("wr_count", wr_log.size() - base, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && base + i < wr_log.size(); i++)
            check_val("wr_entry", wr_log[base+i], exp_wr[i]);
        exp_wr.delete();
    endtask

    // Write transaction of tx_q bytes; first byte is the pointer when the address matches.
    task automatic master_write(input logic [6:0] addr, input logic with_stop);
        logic acked;
        logic match;
        int   base;
        int   oe0;
        match = (addr == TARGET);
        base  = wr_log.size();
        oe0   = oe_cycles;
        i2c_start();
        write_byte({addr, 1'b0}, acked);
        check_val("wr_addr_ack", acked, match);
        check_val("wr_busy", busy, match);
        foreach (tx_q[i]) begin
            write_byte(tx_q[i], acked);
            check_val("wr_data_ack", acked, match);
            if (match) begin
                if (i == 0) begin
                    m_ptr = tx_q[i];
                end else begin
                    exp_wr.push_back({m_ptr, tx_q[i]});
                    m_ptr++;
                end
            end
        end
        check_writes(base);
        if (!match) check_val("wr_no_oe", oe_cycles - oe0, 0);
        if (with_stop) begin
            i2c_stop();
            check_val("wr_busy_stop", busy, 0);
        end
        check_val("wr_ptr", rd_addr, m_ptr);
    endtask

    // Read transaction of n bytes, master NACKs the last one, then STOP.
    task automatic master_read(input logic [6:0] addr, input int n);
        logic       acked;
        logic       match;
        logic [7:0] d;
        int         oe0;
        match = (addr == TARGET);
        oe0   = oe_cycles;
        i2c_start();
        write_byte({addr, 1'b1}, acked);
        check_val("rd_addr_ack", acked, match);
        check_val("rd_busy", busy, match);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            if (match) begin
                check_val("rd_byte", d, regs[m_ptr]);
                m_ptr++;
            end else begin
                check_val("rd_idle_bus", d, 8'hFF);
            end
        end
        i2c_stop();
        check_val("rd_busy_stop", busy, 0);
        check_val("rd_ptr", rd_addr, m_ptr);
        if (!match) check_val("rd_no_oe", oe_cycles - oe0, 0);
    endtask

    initial begin
        logic       acked;
        logic       seen;
        logic [6:0] a;
        int         n;
        int         base;

        for (int i = 0; i < 256; i++) regs[i] = ~8'(i);
        master_scl = 1'b1;
        master_sda = 1'b1;
        rst_n      = 1'b0;
        m_ptr      = 8'h00;
        repeat (5) @(posedge clk_in);
        #1;
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_rd_addr", rd_addr, 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;

        // Pointer then two data bytes.
        tx_q = '{8'h10, 8'hA5, 8'h3C};
        master_write(TARGET, 1'b1);

        // Set pointer, repeated START, read three bytes.
        tx_q = '{8'h05};
        master_write(TARGET, 1'b0);
        master_read(TARGET, 3);
        check_val("rd_ptr_end", rd_addr, 8'h08);

        // Foreign address is ignored.
        tx_q = '{8'h11};
        master_write(7'h2A, 1'b1);

        // Pointer wrap-around.
        tx_q = '{8'hFF, 8'h01, 8'h02};
        master_write(TARGET, 1'b1);

        // STOP in the middle of a data byte discards it.
        base = wr_log.size();
        i2c_start();
        write_byte({TARGET, 1'b0}, acked);
        write_byte(8'h40, acked);
        m_ptr = 8'h40;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), seen);
        i2c_stop();
        check_writes(base);
        check_val("t5_busy", busy, 0);
        tx_q = '{8'h20, 8'h77};
        master_write(TARGET, 1'b1);

        // Reset while the target pulls SDA low during a read.
        tx_q = '{8'h90};
        master_write(TARGET, 1'b0);
        i2c_start();
        write_byte({TARGET, 1'b1}, acked);
        check_val("t6_oe_drive", sda_oe, 1);
        check_val("t6_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_oe", sda_oe, 0);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_ptr", rd_addr, 0);
        m_ptr = 8'h00;
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        base = wr_log.size();
        write_byte({TARGET, 1'b0}, acked);
        check_val("t6_no_ack", acked, 0);
        write_byte(8'h33, acked);
        write_byte(8'h44, acked);
        check_val("t6_no_busy", busy, 0);
        i2c_stop();
        check_writes(base);

        // Randomized transactions against the model.
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        for (int t = 0; t < 16; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TARGET;
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                tx_q.delete();
                for (int k = 0; k < n + 1; k++) tx_q.push_back(8'($urandom));
                master_write(a, 1'b1);
            end else begin
                master_read(a, n);
            end
        end

        check_val("oe_change_scl_high", oe_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
